mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- Memory-stage controller between the pipeline's execute stage and the data cache.
- Accepts one load/store per instruction from EX and drives the cache's read/write/address/data handshake.
- Holds the pipeline stalled until the cache raises its completion flag, then presents the result to writeback.
- Non-memory instructions pass through with one registered cycle of latency.

Parameters:
WORD_SIZE, 32, data and address width in bits (word-addressed, matches the cache).
REG_BITS, 5, destination register index width.
TIMEOUT, 255, maximum cycles to wait for cache completion before aborting.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
ex_valid  input  1  EX stage presents an instruction this cycle.
ex_load  input  1  instruction is a load.
ex_store  input  1  instruction is a store; ex_load and ex_store both high is illegal and treated as load.
ex_addr  input  WORD_SIZE  word address.
ex_wdata  input  WORD_SIZE  store data / ALU result for non-memory ops.
ex_rd  input  REG_BITS  destination register.
flush  input  1  discard the result of the current instruction.
stall  output  1  EX must hold its outputs stable.
dc_addr  output  WORD_SIZE  cache address.
dc_read  output  1  cache read request (level).
dc_write  output  1  cache write request (level).
dc_wdata  output  WORD_SIZE  cache write data.
dc_rdata  input  WORD_SIZE  cache read data.
dc_over  input  1  cache access complete; valid with dc_rdata.
wb_valid  output  1  one-cycle pulse: result for writeback.
wb_rd  output  REG_BITS  destination register for the result.
wb_data  output  WORD_SIZE  load data or passed-through ALU result.
wb_load  output  1  wb_data came from memory.
err_timeout  output  1  sticky; set on cache timeout.

Behaviour:
- Reset (async, rst_n low): state IDLE. dc_read, dc_write, wb_valid, wb_load, err_timeout and stall all 0. dc_addr, dc_wdata, wb_data and wb_rd all 0. Timeout counter 0.
- States: IDLE, ACCESS, GAP.
- IDLE, ex_valid with no memory op: register ex_wdata/ex_rd to wb_*. wb_valid=1 next cycle (suppressed if flush) and wb_load=0. Stays IDLE; stall=0.
- IDLE, ex_valid with a load or store:
  - stall=1 combinationally in the same cycle.
  - Capture addr, wdata, rd and type.
  - Next cycle: enter ACCESS with dc_read or dc_write asserted and dc_addr/dc_wdata stable.
- ACCESS:
  - stall=1 and the request is held constant.
  - Timeout counter increments each cycle.
  - On dc_over=1 at a rising edge: latch dc_rdata (loads) into wb_data, wb_valid=1 for one cycle, wb_load=1 for loads, drop dc_read/dc_write, go to GAP.
  - Stall deasserts in the cycle wb_valid is high.
- GAP: exactly one cycle with dc_read=dc_write=0, so the cache always sees a request falling edge between accesses. stall=1 only if ex_valid presents a memory op. Returns to IDLE. A memory op arriving in GAP is captured at the GAP→IDLE transition; it never overlaps.
- Stores produce wb_valid=1 with wb_load=0, wb_data=0 and wb_rd captured; writeback ignores rd for stores by decode.
- Timeout: when the counter reaches TIMEOUT without dc_over, abort:
  - Drop the request and set err_timeout (sticky until reset).
  - wb_valid=1, wb_data=0.
  - Go to GAP.
- Flush:
  - During ACCESS, the cache access still runs to completion (cannot be aborted), but wb_valid is suppressed for that instruction.
  - Flush during IDLE kills the pass-through result.
  - Flush is remembered until completion.
- dc_over while IDLE/GAP: ignored.
- Reset mid-ACCESS: request lines drop immediately and any in-flight result is lost.
- Throughput:
  - Non-memory ops: 1/cycle.
  - Memory ops: minimum 1 capture + N access + 1 gap cycles, where N≥1 is the cache latency.

Test Plan:
- Reset, then ALU op ex_wdata=32'h0000_00A5, rd=3 → next cycle wb_valid=1, wb_data=32'hA5, wb_rd=3, wb_load=0, stall never high.
- Load addr=1, cache model asserts dc_over 3 cycles after dc_read with rdata=32'h1234_5678 → stall high 5 cycles, dc_addr=1 stable, one wb_valid pulse with wb_data=32'h12345678, wb_load=1, then dc_read low for ≥1 cycle.
- Back-to-back loads addr 0,1,2,3 → four distinct dc_read high periods separated by one low cycle, four wb pulses in order with matching data.
- Store addr=2, wdata=32'hDEAD_BEEF → dc_write high with dc_wdata=32'hDEADBEEF until dc_over, dc_read stays 0, wb_valid pulse with wb_load=0.
- Cache never asserts dc_over → after 255 ACCESS cycles: err_timeout=1, wb_valid pulse with wb_data=0, dc_read drops, controller accepts the next op.
- Flush during load ACCESS → access completes, no wb_valid. rst_n low mid-ACCESS → dc_read=0 and stall=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage controller between EX and the data cache.
// Takes one load/store from EX, runs the cache request handshake, stalls
// EX while the access is in flight and hands the result to writeback.
// Non-memory instructions pass through with one registered cycle.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   ex_valid/load/store         EX instruction and its memory type
//   ex_addr/wdata/rd            word address, store data or ALU result, rd
//   flush                       discard the current instruction's result
//   stall                       EX must hold its outputs
//   dc_addr/read/write/wdata    cache request, held level until dc_over
//   dc_rdata, dc_over           cache read data and completion flag
//   wb_valid/rd/data/load       one-cycle writeback result
//   err_timeout                 sticky cache-timeout flag
module mem_stage_ctrl #(
  parameter int WORD_SIZE = 32,
  parameter int REG_BITS  = 5,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ex_valid,
  input  logic                 ex_load,
  input  logic                 ex_store,
  input  logic [WORD_SIZE-1:0] ex_addr,
  input  logic [WORD_SIZE-1:0] ex_wdata,
  input  logic [REG_BITS-1:0]  ex_rd,
  input  logic                 flush,
  output logic                 stall,
  output logic [WORD_SIZE-1:0] dc_addr,
  output logic                 dc_read,
  output logic                 dc_write,
  output logic [WORD_SIZE-1:0] dc_wdata,
  input  logic [WORD_SIZE-1:0] dc_rdata,
  input  logic                 dc_over,
  output logic                 wb_valid,
  output logic [REG_BITS-1:0]  wb_rd,
  output logic [WORD_SIZE-1:0] wb_data,
  output logic                 wb_load,
  output logic                 err_timeout
);

  localparam int CW =
    (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    GAP
  } state_t;

  typedef enum logic [1:0] {
    OP_ALU,
    OP_LOAD,
    OP_STORE
  } op_t;

  typedef struct packed {
    logic [REG_BITS-1:0] rd;
    logic                load;
    logic                kill;
  } req_t;

  state_t        state;
  state_t        state_nx;
  op_t           op;
  req_t          req;
  logic [CW-1:0] cnt;

  logic ready;
  logic mem_take;
  logic alu_take;
  logic in_access;
  logic done;
  logic abort;
  logic finish;
  logic kill;
  logic good_load;

  // Load wins when both type bits are set.
  always_comb begin
    op = OP_ALU;
    unique case (1'b1)
      ex_load:              op = OP_LOAD;
      ex_store && !ex_load: op = OP_STORE;
      default:              op = OP_ALU;
    endcase
  end

  // IDLE and GAP both accept a new instruction; GAP
  // only differs in that the request lines were low
  // for this cycle, so a memory op taken here starts
  // its access directly after the falling edge.
  assign ready     = (state != ACCESS);
  assign in_access = (state == ACCESS);
  assign mem_take  = ready & ex_valid
                   & (op != OP_ALU);
  assign alu_take  = ready & ex_valid
                   & (op == OP_ALU);

  assign done   = in_access & dc_over;
  assign abort  = in_access & ~dc_over
                & (cnt == CNT_LAST);
  assign finish = done | abort;

  // A flush seen on the finishing edge still counts.
  assign kill      = req.kill | flush;
  assign good_load = done & req.load;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (mem_take) begin
          state_nx = ACCESS;
        end
      end
      ACCESS: begin
        if (finish) begin
          state_nx = GAP;
        end
      end
      GAP: begin
        if (mem_take) begin
          state_nx = ACCESS;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    stall = 1'b0;
    unique case (state)
      ACCESS:  stall = 1'b1;
      default: stall = mem_take;
    endcase
  end

  // Captured instruction context.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req <= '0;
    end else if (mem_take) begin
      req.rd   <= ex_rd;
      req.load <= (op == OP_LOAD);
      req.kill <= flush;
    end else if (in_access) begin
      req.kill <= kill;
    end
  end

  // Cache request: held constant for the whole access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dc_addr  <= '0;
      dc_wdata <= '0;
      dc_read  <= 1'b0;
      dc_write <= 1'b0;
    end else if (mem_take) begin
      dc_addr  <= ex_addr;
      dc_wdata <= ex_wdata;
      dc_read  <= (op == OP_LOAD);
      dc_write <= (op == OP_STORE);
    end else if (finish) begin
      dc_read  <= 1'b0;
      dc_write <= 1'b0;
    end
  end

  // Access watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (mem_take) begin
      cnt <= '0;
    end else if (in_access && !finish) begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_timeout <= 1'b0;
    end else if (abort) begin
      err_timeout <= 1'b1;
    end
  end

  // Writeback result. Stores and aborted accesses
  // return zero data; rd is always forwarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      wb_load  <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      if (alu_take) begin
        wb_valid <= ~flush;
        wb_rd    <= ex_rd;
        wb_data  <= ex_wdata;
        wb_load  <= 1'b0;
      end else if (finish) begin
        wb_valid <= ~kill;
        wb_rd    <= req.rd;
        wb_load  <= good_load;
        wb_data  <= good_load ? dc_rdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: randomized scoreboard bench for mem_stage_ctrl.
// Cache model with its own memory; reference memory drives expectations.
module tb_mem_stage_ctrl;

  localparam int W  = 32;
  localparam int R  = 5;
  localparam int TO = 255;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ex_valid = 1'b0;
  logic         ex_load = 1'b0;
  logic         ex_store = 1'b0;
  logic [W-1:0] ex_addr = '0;
  logic [W-1:0] ex_wdata = '0;
  logic [R-1:0] ex_rd = '0;
  logic         flush = 1'b0;
  logic         stall;
  logic [W-1:0] dc_addr;
  logic         dc_read;
  logic         dc_write;
  logic [W-1:0] dc_wdata;
  logic [W-1:0] dc_rdata = '0;
  logic         dc_over = 1'b0;
  logic         wb_valid;
  logic [R-1:0] wb_rd;
  logic [W-1:0] wb_data;
  logic         wb_load;
  logic         err_timeout;

  mem_stage_ctrl #(
    .WORD_SIZE(W),
    .REG_BITS (R),
    .TIMEOUT  (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_valid   (ex_valid),
    .ex_load    (ex_load),
    .ex_store   (ex_store),
    .ex_addr    (ex_addr),
    .ex_wdata   (ex_wdata),
    .ex_rd      (ex_rd),
    .flush      (flush),
    .stall      (stall),
    .dc_addr    (dc_addr),
    .dc_read    (dc_read),
    .dc_write   (dc_write),
    .dc_wdata   (dc_wdata),
    .dc_rdata   (dc_rdata),
    .dc_over    (dc_over),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .wb_load    (wb_load),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [R-1:0] rd;
    logic [W-1:0] data;
    logic         load;
    bit           chk_load;
  } wb_t;

  typedef struct {
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    logic         load;
  } rq_t;

  wb_t          exp_q[$];
  rq_t          req_q[$];
  int           gap_log[$];
  logic [W-1:0] ref_mem[16];
  logic [W-1:0] cmem[16];

  int n_chk = 0;
  int n_fail = 0;
  bit hung = 0;
  int force_lat = 0;
  bit gap_log_on = 0;
  int stall_cycles = 0;
  int stall_run = 0;
  int last_run = 0;
  int rises = 0;
  int mem_issued = 0;
  int wb_count = 0;

  task automatic check(input string name,
                       input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h",
               name, act, exp);
    end
  endtask

  task automatic check_b(input string name,
                         input logic act,
                         input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b",
               name, act, exp);
    end
  endtask

  // Cache model: answers each request after a random
  // latency, stray dc_over pulses when nothing is asked.
  initial begin : cache
    bit  rq;
    bit  was_rq;
    bit  bad;
    bit  cur_hung;
    int  per_len;
    int  gap_len;
    int  lat;
    rq_t cur;
    was_rq = 0;
    bad = 0;
    cur_hung = 0;
    per_len = 0;
    gap_len = 0;
    lat = 1;
    cur = '{default: '0};
    forever begin
      @(negedge clk);
      dc_over = 1'b0;
      dc_rdata = $urandom;
      if (!rst_n) begin
        was_rq = 0;
        gap_len = 0;
        continue;
      end
      rq = dc_read | dc_write;
      if (rq && !was_rq) begin
        rises++;
        if (gap_log_on) gap_log.push_back(gap_len);
        gap_len = 0;
        per_len = 0;
        bad = 0;
        cur_hung = hung;
        lat = (force_lat != 0) ? force_lat
                               : int'($urandom_range(1, 5));
        if (req_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL dc_req_spurious: got request addr %h, required none", dc_addr);
        end else begin
          cur = req_q.pop_front();
          check("dc_addr", dc_addr, cur.addr);
          check_b("dc_read", dc_read, cur.load);
          check_b("dc_write", dc_write, !cur.load);
          if (!cur.load)
            check("dc_wdata", dc_wdata, cur.wdata);
        end
      end
      if (rq) begin
        per_len++;
        if (dc_addr !== cur.addr ||
            dc_read !== cur.load ||
            dc_write !== !cur.load ||
            (!cur.load && dc_wdata !== cur.wdata))
          bad = 1;
        if (!cur_hung && per_len == lat) begin
          dc_over = 1'b1;
          dc_rdata = cmem[dc_addr[3:0]];
          if (dc_write) cmem[dc_addr[3:0]] = dc_wdata;
        end
      end else begin
        if (was_rq) begin
          check_b("dc_req_unstable", bad, 1'b0);
          if (cur_hung)
            check("timeout_len", W'(per_len), W'(TO));
        end
        gap_len++;
        if ($urandom_range(0, 3) == 0) dc_over = 1'b1;
      end
      was_rq = rq;
    end
  end

  // Writeback monitor: pops the scoreboard on each pulse.
  initial begin : monitor
    wb_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        stall_run = 0;
      end else begin
        if (stall) begin
          stall_cycles++;
          stall_run++;
        end else if (stall_run != 0) begin
          last_run = stall_run;
          stall_run = 0;
        end
        if (wb_valid) begin
          wb_count++;
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL wb_unexpected: got rd %0d data %h, required no pulse", wb_rd, wb_data);
          end else begin
            e = exp_q.pop_front();
            check("wb_rd", W'(wb_rd), W'(e.rd));
            check("wb_data", wb_data, e.data);
            if (e.chk_load)
              check_b("wb_load", wb_load, e.load);
          end
        end
      end
    end
  end

  // kind: 0 alu, 1 load, 2 store, 3 load+store (acts as load)
  task automatic issue(input int kind,
                       input logic [W-1:0] addr,
                       input logic [W-1:0] wdata,
                       input logic [R-1:0] rd,
                       input bit fl_cap,
                       input bit fl_acc);
    int  n = 0;
    bit  is_mem = (kind != 0);
    bit  is_ld = (kind == 1 || kind == 3);
    wb_t e;
    rq_t q;
    @(negedge clk);
    while (stall !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      n_chk++;
      n_fail++;
      $display("FAIL issue_wait: got stall high %0d cycles, required low", n);
    end
    ex_valid = 1'b1;
    ex_load  = (kind == 1 || kind == 3);
    ex_store = (kind == 2 || kind == 3);
    ex_addr  = addr;
    ex_wdata = wdata;
    ex_rd    = rd;
    flush    = fl_cap;
    e.rd = rd;
    if (!is_mem) begin
      e.data = wdata;
      e.load = 1'b0;
      e.chk_load = 1;
      if (!fl_cap) exp_q.push_back(e);
    end else begin
      mem_issued++;
      q.addr = addr;
      q.wdata = wdata;
      q.load = is_ld;
      req_q.push_back(q);
      e.load = is_ld;
      e.chk_load = !hung;
      e.data = (hung || !is_ld) ? '0 : ref_mem[addr[3:0]];
      if (!(fl_cap || fl_acc)) exp_q.push_back(e);
      if (!is_ld && !hung) ref_mem[addr[3:0]] = wdata;
    end
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    ex_load  = 1'b0;
    ex_store = 1'b0;
    flush    = 1'b0;
    if (fl_acc) begin
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    #3;
    while (n < 1000 && (stall || dc_read || dc_write ||
                        exp_q.size() != 0)) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (n >= 1000) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d results pending, required 0", exp_q.size());
    end
    @(negedge clk);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int s0;
    int c0;
    int r0;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      cmem[i] = ref_mem[i];
    end
    ref_mem[1] = 32'h1234_5678;
    cmem[1] = 32'h1234_5678;

    rst_n = 1'b0;
    #3;
    check_b("rst_stall", stall, 1'b0);
    check_b("rst_dc_read", dc_read, 1'b0);
    check_b("rst_dc_write", dc_write, 1'b0);
    check_b("rst_wb_valid", wb_valid, 1'b0);
    check_b("rst_wb_load", wb_load, 1'b0);
    check_b("rst_err", err_timeout, 1'b0);
    check("rst_dc_addr", dc_addr, '0);
    check("rst_dc_wdata", dc_wdata, '0);
    check("rst_wb_data", wb_data, '0);
    check("rst_wb_rd", W'(wb_rd), '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    s0 = stall_cycles;
    issue(0, '0, 32'h0000_00A5, 5'd3, 0, 0);
    drain();
    check("alu_stall_cycles", W'(stall_cycles), W'(s0));

    force_lat = 4;
    issue(1, 32'd1, $urandom, 5'd7, 0, 0);
    drain();
    force_lat = 0;
    check("load_stall_len", W'(last_run), W'(5));

    gap_log.delete();
    gap_log_on = 1;
    for (int a = 0; a < 4; a++)
      issue(1, W'(a), $urandom, R'(a + 8), 0, 0);
    drain();
    gap_log_on = 0;
    check("b2b_periods", W'(gap_log.size()), W'(4));
    for (int i = 1; i < 4; i++)
      if (i < gap_log.size())
        check("b2b_gap", W'(gap_log[i]), W'(1));

    issue(2, 32'd2, 32'hDEAD_BEEF, 5'd9, 0, 0);
    drain();
    check("store_mem", cmem[2], 32'hDEAD_BEEF);
    issue(1, 32'd2, '0, 5'd10, 0, 0);
    drain();

    c0 = wb_count;
    r0 = rises;
    issue(1, 32'd4, '0, 5'd11, 0, 1);
    drain();
    check("flush_acc_wb", W'(wb_count), W'(c0));
    check("flush_acc_ran", W'(rises), W'(r0 + 1));
    issue(0, '0, 32'h55, 5'd12, 1, 0);
    drain();
    check("flush_alu_wb", W'(wb_count), W'(c0));

    for (int i = 0; i < 150; i++) begin
      int  k;
      bit  fc;
      bit  fa;
      k  = int'($urandom_range(0, 3));
      fc = ($urandom_range(0, 7) == 0);
      fa = (k != 0) && ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) @(negedge clk);
      issue(k, $urandom, $urandom, R'($urandom), fc, fa);
    end
    drain();

    check_b("err_before_to", err_timeout, 1'b0);
    hung = 1;
    issue(1, 32'd5, '0, 5'd13, 0, 0);
    drain();
    hung = 0;
    check_b("err_after_to", err_timeout, 1'b1);
    issue(0, '0, 32'hCAFE_0001, 5'd14, 0, 0);
    issue(1, 32'd6, '0, 5'd15, 0, 0);
    drain();
    check_b("err_sticky", err_timeout, 1'b1);

    hung = 1;
    issue(1, 32'd7, '0, 5'd16, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #3;
    check_b("pre_rst_read", dc_read, 1'b1);
    rst_n = 1'b0;
    #1;
    check_b("mid_rst_read", dc_read, 1'b0);
    check_b("mid_rst_stall", stall, 1'b0);
    check_b("mid_rst_wb", wb_valid, 1'b0);
    exp_q.delete();
    req_q.delete();
    hung = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_b("err_cleared", err_timeout, 1'b0);
    issue(0, '0, 32'h0BAD_F00D, 5'd17, 0, 0);
    issue(1, 32'd3, '0, 5'd18, 0, 0);
    drain();

    check("final_pending", W'(exp_q.size()), '0);
    check("req_periods", W'(rises), W'(mem_issued));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
